// File: rtl/fifo_serial_tx.sv
// -----------------------------------------------------------------------------
// fifo_serial_tx
//   Pops words from an upstream FIFO and sends each one as a UART-style frame:
//   one start bit (0), WIDTH data bits LSB first, one stop bit (1). Each bit
//   lasts CLKS_PER_BIT clocks. Consecutive frames go out back-to-back while
//   tx_en is high and the FIFO is not empty. Between frames the line carries
//   exactly two high cycles, one for POP and one for LOAD.
//
// Parameters
//   WIDTH         FIFO word width and number of data bits per frame
//   CLKS_PER_BIT  clocks per serial bit, 2..255
//
// Ports
//   clk         clock; every register updates on the rising edge
//   rst_n       synchronous active-low reset
//   tx_en       allows a new frame to start; sampled only in IDLE and at the
//               end of STOP, so dropping it mid-frame never cuts a frame short
//   fifo_empty  upstream FIFO empty flag
//   fifo_rdata  upstream FIFO read data, valid the cycle after a fifo_rd pulse
//   fifo_rd     one-cycle pop request (registered)
//   tx          serial line, idles high (registered)
//   busy        high whenever the FSM is not in IDLE (registered)
//   frame_done  one-cycle pulse on the last cycle of the stop bit (registered)
// -----------------------------------------------------------------------------
module fifo_serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_rd,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;

    logic tx_q, tx_d;
    logic fifo_rd_q, fifo_rd_d;
    logic busy_q, busy_d;
    logic frame_done_q, frame_done_d;

    // Next-state, shift register and counter logic.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (tx_en && !fifo_empty) begin
                    state_d = ST_POP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_POP: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // Data requested in POP is presented by the FIFO this cycle.
                shift_d = fifo_rdata;
                cnt_d   = '0;
                idx_d   = '0;
                state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1'b1;
                    if (idx_q == IDX_MAX) begin
                        idx_d   = '0;
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    if (tx_en && !fifo_empty) begin
                        state_d = ST_POP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Output values are decoded from the next state, so once registered they
    // line up exactly with the state the FSM occupies.
    always_comb begin
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
        fifo_rd_d    = (state_d == ST_POP);
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_d == ST_STOP) && (cnt_d == CNT_MAX);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            tx_q         <= 1'b1;
            fifo_rd_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            tx_q         <= tx_d;
            fifo_rd_q    <= fifo_rd_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tx         = tx_q;
    assign fifo_rd    = fifo_rd_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_serial_tx
//   Directed bench for fifo_serial_tx with WIDTH=8, CLKS_PER_BIT=4. Inputs
//   change just after each falling edge. Outputs are checked on every falling
//   edge against hand-computed frame bit patterns. fifo_rdata carries random
//   values in every cycle except the cycle in which the DUT captures it.
// -----------------------------------------------------------------------------
module tb_fifo_serial_tx;

    logic       clk;
    logic       rst_n;
    logic       tx_en;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       fifo_rd;
    logic       tx;
    logic       busy;
    logic       frame_done;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int rd_snap;

    fifo_serial_tx #(
        .WIDTH        (8),
        .CLKS_PER_BIT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each record is one frame. bits lists the line level per bit time in
    // transmission order: start, d0..d7, stop. more = another frame follows
    // directly after this one.
    typedef struct {
        logic [7:0] data;
        logic [0:9] bits;
        bit         more;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic e_tx, input logic e_rd,
                       input logic e_busy, input logic e_fd);
        checks++;
        if ({tx, fifo_rd, busy, frame_done} !== {e_tx, e_rd, e_busy, e_fd}) begin
            errors++;
            $display("FAIL %s: tx/rd/busy/done got %b%b%b%b expected %b%b%b%b",
                     nm, tx, fifo_rd, busy, frame_done, e_tx, e_rd, e_busy, e_fd);
        end
        checks++;
        if (fifo_rd === 1'b1 && fifo_empty === 1'b1) begin
            errors++;
            $display("FAIL %s underflow: fifo_rd got 1 expected 0 while empty", nm);
        end
        if (fifo_rd === 1'b1) rd_cnt++;
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Precondition: the next rising edge moves the DUT into POP.
    task automatic run_frame(input logic [7:0] d, input logic [0:9] eb,
                             input bit more, input bit keep_full,
                             input int drop_k, input int abort_k,
                             input string nm);
        @(negedge clk);
        chk({nm, "/pop"}, 1'b1, 1'b1, 1'b1, 1'b0);
        fifo_rdata = d;
        @(negedge clk);
        chk({nm, "/load"}, 1'b1, 1'b0, 1'b1, 1'b0);
        if (!keep_full) fifo_empty = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk($sformatf("%s/c%0d", nm, k), eb[k/4], 1'b0, 1'b1, (k == 39));
            fifo_rdata = 8'($urandom);
            if (k == drop_k) tx_en = 1'b0;
            if (k == abort_k) begin
                rst_n = 1'b0;
                return;
            end
            if (k == 39 && more) fifo_empty = 1'b0;
        end
    endtask

    initial begin
        vecs[0] = '{8'hA5, 10'b0101001011, 1'b0};
        vecs[1] = '{8'hFF, 10'b0111111111, 1'b1};
        vecs[2] = '{8'h00, 10'b0000000001, 1'b0};
        vecs[3] = '{8'h80, 10'b0000000011, 1'b1};
        vecs[4] = '{8'h01, 10'b0100000001, 1'b0};

        rst_n      = 1'b0;
        tx_en      = 1'b0;
        fifo_empty = 1'b1;
        fifo_rdata = 8'h00;

        // Reset state.
        @(negedge clk);
        chk("reset0", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("reset1", 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Empty FIFO with tx_en high: nothing happens.
        tx_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk($sformatf("empty/c%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
            fifo_rdata = 8'($urandom);
        end
        chk_int("empty_rd_pulses", rd_cnt, 0);

        // Frame table: single frames and back-to-back pairs.
        rd_snap = rd_cnt;
        for (int i = 0; i < 5; i++) begin
            if (i == 0 || !vecs[i-1].more) fifo_empty = 1'b0;
            run_frame(vecs[i].data, vecs[i].bits, vecs[i].more, 1'b0, -1, -1,
                      $sformatf("vec%0d", i));
            if (!vecs[i].more) begin
                @(negedge clk);
                chk($sformatf("vec%0d/idle", i), 1'b1, 1'b0, 1'b0, 1'b0);
            end
        end
        chk_int("table_rd_pulses", rd_cnt - rd_snap, 5);

        // tx_en dropped during DATA of 0x3C, FIFO left non-empty.
        rd_snap    = rd_cnt;
        tx_en      = 1'b1;
        fifo_empty = 1'b0;
        run_frame(8'h3C, 10'b0001111001, 1'b0, 1'b1, 10, -1, "txen_drop");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("txen_drop/idle%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk_int("txen_drop_rd_pulses", rd_cnt - rd_snap, 1);
        fifo_empty = 1'b1;
        tx_en      = 1'b1;

        // Reset for two cycles during data bit 3, then a clean frame.
        fifo_empty = 1'b0;
        run_frame(8'hA5, 10'b0101001011, 1'b0, 1'b1, -1, 17, "rst_mid");
        @(negedge clk);
        chk("rst_mid/hold0", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_mid/hold1", 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        run_frame(8'hC3, 10'b0110000111, 1'b0, 1'b0, -1, -1, "after_rst");
        @(negedge clk);
        chk("after_rst/idle", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
